// File: rtl/board_ctrl_m.sv
// -----------------------------------------------------------------------------
// board_ctrl_m
// Parametrised game-board controller. It holds a ROWS x COLS board of 2-bit
// cells and accepts moves over a valid/ready port. Each move is validated and
// answered with a one-cycle response. After every accepted move it scans the
// board, one start cell per cycle, for WIN_LEN of the mover's marks in a row
// and reports a win or a draw.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   clear        synchronous new-game request (beats any move)
//   move_valid   move request present
//   move_ready   controller can take a move this cycle
//   move_row     target row
//   move_col     target column
//   move_player  0 = X, 1 = O
//   resp_valid   one-cycle pulse carrying the response to the last handshake
//   resp_code    0 OK, 1 OCCUPIED, 2 BAD_POS, 3 WRONG_TURN, 4 GAME_OVER
//   board        cell i = r*COLS+c at [2i+1:2i]; 00 blank, 01 X, 10 O
//   turn         player expected next (0 = X)
//   move_count   accepted moves since reset/clear (saturates at NCELL)
//   game_state   0 in progress, 1 X win, 2 O win, 3 draw
// -----------------------------------------------------------------------------
module board_ctrl_m #(
    parameter int  ROWS    = 3,
    parameter int  COLS    = 3,
    parameter int  WIN_LEN = 3,
    localparam int NCELL   = ROWS * COLS,
    localparam int RW      = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
    localparam int CW      = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
    localparam int NW      = $clog2(NCELL + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [RW-1:0]      move_row,
    input  logic [CW-1:0]      move_col,
    input  logic               move_player,
    output logic               resp_valid,
    output logic [2:0]         resp_code,
    output logic [2*NCELL-1:0] board,
    output logic               turn,
    output logic [NW-1:0]      move_count,
    output logic [1:0]         game_state
);

    localparam int KW = ($clog2(NCELL) > 1) ? $clog2(NCELL) : 1;

    localparam logic [2:0] RC_OK         = 3'd0;
    localparam logic [2:0] RC_OCCUPIED   = 3'd1;
    localparam logic [2:0] RC_BAD_POS    = 3'd2;
    localparam logic [2:0] RC_WRONG_TURN = 3'd3;
    localparam logic [2:0] RC_GAME_OVER  = 3'd4;

    localparam logic [1:0] GS_PLAYING = 2'd0;
    localparam logic [1:0] GS_X_WIN   = 2'd1;
    localparam logic [1:0] GS_O_WIN   = 2'd2;
    localparam logic [1:0] GS_DRAW    = 2'd3;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg,      state_next;
    logic [2*NCELL-1:0] board_reg,      board_next;
    logic               turn_reg,       turn_next;
    logic [NW-1:0]      count_reg,      count_next;
    logic [1:0]         game_state_reg, game_state_next;
    logic               resp_valid_reg, resp_valid_next;
    logic [2:0]         resp_code_reg,  resp_code_next;
    logic [KW-1:0]      scan_k_reg,     scan_k_next;
    logic [1:0]         mover_mark_reg, mover_mark_next;

    logic               handshake;
    logic               pos_ok;
    int                 cell_idx;
    logic [1:0]         target_cell;
    logic [2:0]         check_code;
    logic [NCELL-1:0]   win_at;
    logic               scan_hit;

    // ------------------------------------------------------------------
    // Move validation (first match wins)
    // ------------------------------------------------------------------
    assign move_ready = !clear && (state_reg != ST_CHECK);
    assign handshake  = move_valid && move_ready;

    always_comb begin
        pos_ok      = (int'(move_row) < ROWS) && (int'(move_col) < COLS);
        // Out-of-range positions are clamped to cell 0 so the board lookup
        // never leaves the vector; the code below rejects them anyway.
        cell_idx    = pos_ok ? (int'(move_row) * COLS + int'(move_col)) : 0;
        target_cell = board_reg[2*cell_idx +: 2];
        if (state_reg == ST_DONE) begin
            check_code = RC_GAME_OVER;
        end else if (!pos_ok) begin
            check_code = RC_BAD_POS;
        end else if (move_player != turn_reg) begin
            check_code = RC_WRONG_TURN;
        end else if (target_cell != 2'b00) begin
            check_code = RC_OCCUPIED;
        end else begin
            check_code = RC_OK;
        end
    end

    // ------------------------------------------------------------------
    // Line detection: for every start cell, test right, down, down-right and
    // down-left for WIN_LEN cells holding the mover's mark. Directions that
    // would leave the board are disabled at elaboration time; their cell
    // indices are clamped to the start cell so no selection goes out of range.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_win
            localparam int R      = gi / COLS;
            localparam int C      = gi % COLS;
            localparam bit FIT_R  = (C + WIN_LEN <= COLS);
            localparam bit FIT_D  = (R + WIN_LEN <= ROWS);
            localparam bit FIT_DR = FIT_R && FIT_D;
            localparam bit FIT_DL = (C + 1 >= WIN_LEN) && FIT_D;

            logic line_r, line_d, line_dr, line_dl;

            always_comb begin
                line_r  = FIT_R;
                line_d  = FIT_D;
                line_dr = FIT_DR;
                line_dl = FIT_DL;
                for (int j = 0; j < WIN_LEN; j++) begin
                    if (board_reg[2*(FIT_R  ? gi + j             : gi) +: 2] != mover_mark_reg)
                        line_r = 1'b0;
                    if (board_reg[2*(FIT_D  ? gi + j*COLS        : gi) +: 2] != mover_mark_reg)
                        line_d = 1'b0;
                    if (board_reg[2*(FIT_DR ? gi + j*(COLS + 1)  : gi) +: 2] != mover_mark_reg)
                        line_dr = 1'b0;
                    if (board_reg[2*(FIT_DL ? gi + j*(COLS - 1)  : gi) +: 2] != mover_mark_reg)
                        line_dl = 1'b0;
                end
            end

            assign win_at[gi] = line_r | line_d | line_dr | line_dl;
        end
    endgenerate

    assign scan_hit = win_at[scan_k_reg];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        board_next      = board_reg;
        turn_next       = turn_reg;
        count_next      = count_reg;
        game_state_next = game_state_reg;
        resp_valid_next = 1'b0;
        resp_code_next  = resp_code_reg;
        scan_k_next     = scan_k_reg;
        mover_mark_next = mover_mark_reg;

        if (clear) begin
            // New game: also abandons any scan in flight.
            state_next      = ST_IDLE;
            board_next      = '0;
            turn_next       = 1'b0;
            count_next      = '0;
            game_state_next = GS_PLAYING;
            resp_code_next  = RC_OK;
            scan_k_next     = '0;
            mover_mark_next = 2'b00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        resp_valid_next = 1'b1;
                        resp_code_next  = check_code;
                        if (check_code == RC_OK) begin
                            board_next[2*cell_idx +: 2] = move_player ? MARK_O : MARK_X;
                            mover_mark_next = move_player ? MARK_O : MARK_X;
                            turn_next       = ~turn_reg;
                            if (count_reg != NW'(NCELL))
                                count_next = count_reg + 1'b1;
                            scan_k_next     = '0;
                            state_next      = ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (scan_hit) begin
                        game_state_next = (mover_mark_reg == MARK_X) ? GS_X_WIN : GS_O_WIN;
                        state_next      = ST_DONE;
                    end else if (scan_k_reg == KW'(NCELL - 1)) begin
                        if (count_reg == NW'(NCELL)) begin
                            game_state_next = GS_DRAW;
                            state_next      = ST_DONE;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        scan_k_next = scan_k_reg + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (handshake) begin
                        resp_valid_next = 1'b1;
                        resp_code_next  = check_code;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            board_reg      <= '0;
            turn_reg       <= 1'b0;
            count_reg      <= '0;
            game_state_reg <= GS_PLAYING;
            resp_valid_reg <= 1'b0;
            resp_code_reg  <= RC_OK;
            scan_k_reg     <= '0;
            mover_mark_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            board_reg      <= board_next;
            turn_reg       <= turn_next;
            count_reg      <= count_next;
            game_state_reg <= game_state_next;
            resp_valid_reg <= resp_valid_next;
            resp_code_reg  <= resp_code_next;
            scan_k_reg     <= scan_k_next;
            mover_mark_reg <= mover_mark_next;
        end
    end

    assign board      = board_reg;
    assign turn       = turn_reg;
    assign move_count = count_reg;
    assign game_state = game_state_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_code  = resp_code_reg;

endmodule

// File: tb/tb_board_ctrl_m.sv
// -----------------------------------------------------------------------------
// tb_board_ctrl_m
// Self-checking bench for board_ctrl_m. Two instances: a default 3x3 board
// (dut_a) and a 4x5 board with WIN_LEN=4 (dut_b). Moves come from a table;
// the expected response code is queued when a move is driven and popped when
// the matching DUT raises resp_valid. Board/turn/count/state are checked by
// hand-written sequences between table ranges.
// -----------------------------------------------------------------------------
module tb_board_ctrl_m;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       clear;
    logic       move_valid;
    logic       move_player;
    logic       sel;
    logic [1:0] move_row;
    logic [2:0] move_col;

    logic        ready_a, resp_valid_a, turn_a;
    logic [2:0]  resp_code_a;
    logic [17:0] board_a;
    logic [3:0]  count_a;
    logic [1:0]  gs_a;

    logic        ready_b, resp_valid_b, turn_b;
    logic [2:0]  resp_code_b;
    logic [39:0] board_b;
    logic [4:0]  count_b;
    logic [1:0]  gs_b;

    board_ctrl_m dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .move_valid  (move_valid & ~sel),
        .move_ready  (ready_a),
        .move_row    (move_row),
        .move_col    (move_col[1:0]),
        .move_player (move_player),
        .resp_valid  (resp_valid_a),
        .resp_code   (resp_code_a),
        .board       (board_a),
        .turn        (turn_a),
        .move_count  (count_a),
        .game_state  (gs_a)
    );

    board_ctrl_m #(.ROWS(4), .COLS(5), .WIN_LEN(4)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .move_valid  (move_valid & sel),
        .move_ready  (ready_b),
        .move_row    (move_row),
        .move_col    (move_col),
        .move_player (move_player),
        .resp_valid  (resp_valid_b),
        .resp_code   (resp_code_b),
        .board       (board_b),
        .turn        (turn_b),
        .move_count  (count_b),
        .game_state  (gs_b)
    );

    typedef struct {
        bit b_dut;
        int row;
        int col;
        bit player;
        int code;
    } vec_t;

    localparam int NV = 32;
    vec_t vec [0:NV-1];

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    int exp_a, exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response scoreboards, one line per transaction.
    always @(negedge clock) begin
        if (resp_valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_a_unexpected: got code %0d expected no response", resp_code_a);
            end else begin
                exp_a = q_a.pop_front();
                $display("resp dut_a code=%0d expected=%0d", resp_code_a, exp_a);
                chk("resp_code_a", resp_code_a, exp_a);
            end
        end
    end

    always @(negedge clock) begin
        if (resp_valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_b_unexpected: got code %0d expected no response", resp_code_b);
            end else begin
                exp_b = q_b.pop_front();
                $display("resp dut_b code=%0d expected=%0d", resp_code_b, exp_b);
                chk("resp_code_b", resp_code_b, exp_b);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clock);
        while (!(sel ? ready_b : ready_a) && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("move_ready_wait", sel ? ready_b : ready_a, 1);
    endtask

    task automatic do_move(input vec_t v);
        sel = v.b_dut;
        wait_ready();
        move_row    = v.row[1:0];
        move_col    = v.col[2:0];
        move_player = v.player;
        move_valid  = 1'b1;
        if (v.b_dut) q_b.push_back(v.code);
        else         q_a.push_back(v.code);
        @(posedge clock);
        #1 move_valid = 1'b0;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) do_move(vec[i]);
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // test 1: X wins top row; then a move after the win
        vec[0]  = '{1'b0, 0, 0, 1'b0, 0};
        vec[1]  = '{1'b0, 1, 0, 1'b1, 0};
        vec[2]  = '{1'b0, 0, 1, 1'b0, 0};
        vec[3]  = '{1'b0, 1, 1, 1'b1, 0};
        vec[4]  = '{1'b0, 0, 2, 1'b0, 0};
        vec[5]  = '{1'b0, 2, 2, 1'b1, 4};
        // test 2: occupied cell; wrong turn outranks occupied
        vec[6]  = '{1'b0, 1, 1, 1'b0, 0};
        vec[7]  = '{1'b0, 1, 1, 1'b0, 3};
        vec[8]  = '{1'b0, 1, 1, 1'b1, 1};
        // test 3: wrong turn and bad positions on a fresh board
        vec[9]  = '{1'b0, 0, 0, 1'b1, 3};
        vec[10] = '{1'b0, 3, 0, 1'b0, 2};
        vec[11] = '{1'b0, 0, 3, 1'b0, 2};
        // test 4: draw, then game-over (which outranks bad position)
        vec[12] = '{1'b0, 0, 0, 1'b0, 0};
        vec[13] = '{1'b0, 0, 1, 1'b1, 0};
        vec[14] = '{1'b0, 0, 2, 1'b0, 0};
        vec[15] = '{1'b0, 1, 1, 1'b1, 0};
        vec[16] = '{1'b0, 1, 0, 1'b0, 0};
        vec[17] = '{1'b0, 1, 2, 1'b1, 0};
        vec[18] = '{1'b0, 2, 1, 1'b0, 0};
        vec[19] = '{1'b0, 2, 0, 1'b1, 0};
        vec[20] = '{1'b0, 2, 2, 1'b0, 0};
        vec[21] = '{1'b0, 0, 0, 1'b1, 4};
        vec[22] = '{1'b0, 3, 3, 1'b0, 4};
        // test 5: one accepted move, then clear mid-scan
        vec[23] = '{1'b0, 0, 0, 1'b0, 0};
        // test 6: 4x5 board, anti-diagonal win
        vec[24] = '{1'b1, 0, 5, 1'b0, 2};
        vec[25] = '{1'b1, 0, 4, 1'b0, 0};
        vec[26] = '{1'b1, 0, 0, 1'b1, 0};
        vec[27] = '{1'b1, 1, 3, 1'b0, 0};
        vec[28] = '{1'b1, 0, 1, 1'b1, 0};
        vec[29] = '{1'b1, 2, 2, 1'b0, 0};
        vec[30] = '{1'b1, 0, 2, 1'b1, 0};
        vec[31] = '{1'b1, 3, 1, 1'b0, 0};

        reset_n     = 1'b0;
        clear       = 1'b0;
        move_valid  = 1'b0;
        move_player = 1'b0;
        move_row    = '0;
        move_col    = '0;
        sel         = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // reset state
        @(negedge clock);
        chk("rst_board",      board_a, 0);
        chk("rst_turn",       turn_a, 0);
        chk("rst_count",      count_a, 0);
        chk("rst_game_state", gs_a, 0);
        chk("rst_resp_valid", resp_valid_a, 0);
        chk("rst_resp_code",  resp_code_a, 0);
        chk("rst_ready",      ready_a, 1);

        // test 1
        run_range(0, 4);
        wait_ready();
        chk("t1_game_state", gs_a, 1);
        chk("t1_ready",      ready_a, 1);
        chk("t1_board_row0", board_a[5:0], 6'b010101);
        chk("t1_count",      count_a, 5);
        chk("t1_turn",       turn_a, 1);
        run_range(5, 5);

        // test 2
        do_clear();
        run_range(6, 8);
        wait_ready();
        chk("t2_cell4",  board_a[9:8], 2'b01);
        chk("t2_turn",   turn_a, 1);
        chk("t2_count",  count_a, 1);

        // test 3
        do_clear();
        run_range(9, 11);
        wait_ready();
        chk("t3_board",      board_a, 0);
        chk("t3_turn",       turn_a, 0);
        chk("t3_count",      count_a, 0);
        chk("t3_game_state", gs_a, 0);

        // test 4
        do_clear();
        run_range(12, 20);
        wait_ready();
        chk("t4_game_state", gs_a, 3);
        chk("t4_count",      count_a, 9);
        chk("t4_board",      board_a, 18'b010110101001011001);
        run_range(21, 22);

        // test 5: clear with move_valid high while the scan is running
        do_clear();
        run_range(23, 23);
        @(negedge clock);
        clear       = 1'b1;
        move_valid  = 1'b1;
        move_row    = 2'd1;
        move_col    = 3'd1;
        move_player = 1'b1;
        #1;
        chk("t5_ready_during_clear", ready_a, 0);
        @(posedge clock);
        #1;
        clear      = 1'b0;
        move_valid = 1'b0;
        @(negedge clock);
        chk("t5_board",      board_a, 0);
        chk("t5_turn",       turn_a, 0);
        chk("t5_count",      count_a, 0);
        chk("t5_game_state", gs_a, 0);
        chk("t5_resp_valid", resp_valid_a, 0);
        chk("t5_ready",      ready_a, 1);
        repeat (12) @(negedge clock);
        chk("t5_no_late_result", gs_a, 0);

        // test 6
        do_clear();
        run_range(24, 31);
        n = 0;
        while (gs_b != 2'd1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("t6_game_state",  gs_b, 1);
        chk("t6_latency_ok",  (n <= 21), 1);
        chk("t6_count",       count_b, 7);
        chk("t6_cell_0_4",    board_b[9:8], 2'b01);
        chk("t6_ready",       ready_b, 1);

        repeat (4) @(negedge clock);
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
